mem_port_arbiter: RTL

- Shares one single-ported unified instruction/data memory between the Fetch stage (IF) and the Memory stage (MEM) of the pipelined core.
- Grants the bus to one requester at a time and drives the variable-latency req/ack memory handshake.
- Returns read data with a one-cycle ready pulse; the hazard unit uses the stall outputs to freeze F/D (fetch) or the whole pipe (mem).

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / MEM) arbiter for a single-ported memory with a req/ack bus handshake.
// Optional bus watchdog and sticky bus_err are compiled in with `define MEMARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        stall_f,
   output logic        stall_m,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_MEM = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] streak_q, streak_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          we_q, we_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   mem_rdata_q, mem_rdata_d;
   logic          if_ready_q, if_ready_d;
   logic          mem_ready_q, mem_ready_d;
   logic          if_elig, mem_elig, grant_if, grant_mem, timed_out;
`ifdef MEMARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;
`endif

   // A requester still holding req during its own ready pulse is not eligible.
   assign if_elig   = if_req & ~if_ready_q;
   assign mem_elig  = mem_req & ~mem_ready_q;
   assign grant_mem = (state_q == IDLE) && mem_elig && ((streak_q < STREAK_MAX) || !if_elig);
   assign grant_if  = (state_q == IDLE) && if_elig && !grant_mem;

   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      timed_out   = 1'b0;
`ifdef MEMARB_TIMEOUT_EN
      tmo_d       = tmo_q;
      err_d       = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_mem) begin
               state_d = BUSY_MEM;
               addr_d  = mem_addr;
               we_d    = mem_we;
               wdata_d = mem_wdata;
               if (if_elig) streak_d = streak_q + SW'(1);
`ifdef MEMARB_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end else if (grant_if) begin
               state_d  = BUSY_IF;
               addr_d   = if_addr;
               we_d     = 1'b0;
               wdata_d  = '0;
               streak_d = '0;
`ifdef MEMARB_TIMEOUT_EN
               tmo_d    = '0;
`endif
            end
         end
         BUSY_IF, BUSY_MEM: begin
`ifdef MEMARB_TIMEOUT_EN
            tmo_d     = tmo_q + TW'(1);
            timed_out = !bus_ack && (tmo_q == TMO_LAST);
            if (timed_out) err_d = 1'b1;
`endif
            if (bus_ack || timed_out) begin
               state_d = IDLE;
               if (state_q == BUSY_IF) begin
                  // A flushed fetch still finishes on the bus but is not reported.
                  if_rdata_d = timed_out ? '0 : bus_rdata;
                  if_ready_d = if_req;
               end else begin
                  mem_rdata_d = (timed_out || we_q) ? '0 : bus_rdata;
                  mem_ready_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (!if_req) streak_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         if_rdata_q  <= '0;
         mem_rdata_q <= '0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
`ifdef MEMARB_TIMEOUT_EN
         tmo_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
`ifdef MEMARB_TIMEOUT_EN
         tmo_q       <= tmo_d;
         err_q       <= err_d;
`endif
      end
   end

   assign if_rdata  = if_rdata_q;
   assign if_ready  = if_ready_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_ready = mem_ready_q;
   assign stall_f   = if_req & ~if_ready_q;
   assign stall_m   = mem_req & ~mem_ready_q;
   assign bus_req   = (state_q != IDLE);
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
`ifdef MEMARB_TIMEOUT_EN
   assign bus_err   = err_q;
`else
   assign bus_err   = 1'b0;
`endif

endmodule
